// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES sequencer types and constants
package aes_pkg;

   localparam int NR_128  = 10;
   localparam int NR_192  = 12;
   localparam int NR_256  = 14;
   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {
      KIND_FIRST = 2'd0,
      KIND_MID   = 2'd1,
      KIND_LAST  = 2'd2
   } round_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - request/response handshake bundle for the round sequencer
interface aes_round_sequencer_if
   import aes_pkg::*;
();
   logic               in_valid;
   logic               in_ready;
   logic               in_decrypt;
   logic [BLOCK_W-1:0] in_block;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_block;

   // master is the bus shim issuing requests, slave is the sequencer
   modport master (
      output in_valid, in_decrypt, in_block, out_ready,
      input  in_ready, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_decrypt, in_block, out_ready,
      output in_ready, out_valid, out_block
   );
endinterface

// File: rtl/aes_seq_round_ctr.sv
// rtl/aes_seq_round_ctr.sv - round counter, last-round flag and key-slice index generation
module aes_seq_round_ctr
   import aes_pkg::*;
#(
   parameter int NR = NR_192,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_step,
   input  logic          i_decrypt,
   output logic          o_last,
   output logic [RW-1:0] o_round,
   output round_kind_e   o_kind
);
   localparam logic [RW-1:0] LP_NR = RW'(NR);

   logic [RW-1:0] r_ctr;

   // saturates at NR so DONE keeps presenting the last round
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctr <= '0;
      end else if (i_clear) begin
         r_ctr <= '0;
      end else if (i_step && !o_last) begin
         r_ctr <= r_ctr + RW'(1);
      end
   end

   assign o_last  = (r_ctr == LP_NR);
   assign o_round = i_decrypt ? (LP_NR - r_ctr) : r_ctr;

   always_comb begin
      o_kind = KIND_MID;
      if (r_ctr == '0) begin
         o_kind = KIND_FIRST;
      end else if (o_last) begin
         o_kind = KIND_LAST;
      end
   end
endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - steps the shared AES round datapath through NR+1 cycles per block
// Defining AES_SEQ_ABORT_EN adds an abort input that cancels a request in RUN or DONE.
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR = NR_192,
   parameter int RW = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_round_sequencer_if.slave bus,
   output logic [BLOCK_W-1:0]   dp_state,
   output logic [RW-1:0]        dp_round,
   output logic [1:0]           dp_kind,
   output logic                 dp_decrypt,
   input  logic [BLOCK_W-1:0]   dp_result,
`ifdef AES_SEQ_ABORT_EN
   input  logic                 abort,
`endif
   output logic                 busy
);
   seq_state_e         r_state;
   seq_state_e         w_next;
   logic [BLOCK_W-1:0] r_st;
   logic               r_dir;
   logic               w_accept;
   logic               w_abort;
   logic               w_last;
   round_kind_e        w_kind;

`ifdef AES_SEQ_ABORT_EN
   assign w_abort = abort && (r_state != ST_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_accept      = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (r_state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) begin
               w_accept = 1'b1;
               w_next   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            busy   = 1'b0;
            w_next = ST_IDLE;
         end
      endcase
      // abort outranks a pending out handshake
      if (w_abort) begin
         w_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st  <= '0;
         r_dir <= 1'b0;
      end else if (w_abort) begin
         r_st  <= '0;
      end else if (w_accept) begin
         r_st  <= bus.in_block;
         r_dir <= bus.in_decrypt;
      end else if (r_state == ST_RUN) begin
         r_st  <= dp_result;
      end
   end

   aes_seq_round_ctr #(
      .NR (NR),
      .RW (RW)
   ) u_round_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_accept || w_abort),
      .i_step    (r_state == ST_RUN),
      .i_decrypt (r_dir),
      .o_last    (w_last),
      .o_round   (dp_round),
      .o_kind    (w_kind)
   );

   assign dp_state      = r_st;
   assign dp_decrypt    = r_dir;
   assign dp_kind       = w_kind;
   assign bus.out_block = r_st;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed bench with an AES-192 round model as the datapath
module tb_aes_round_sequencer;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

   logic         clk;
   logic         rst_n;
   logic [127:0] dp_state;
   logic [3:0]   dp_round;
   logic [1:0]   dp_kind;
   logic         dp_decrypt;
   logic [127:0] dp_result;
   logic         busy;
`ifdef AES_SEQ_ABORT_EN
   logic         abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox_t  [256];
   logic [7:0]   isbox_t [256];
   logic [127:0] rk      [16];

   aes_round_sequencer_if bus ();

   aes_round_sequencer #(
      .NR (12),
      .RW (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .dp_state   (dp_state),
      .dp_round   (dp_round),
      .dp_kind    (dp_kind),
      .dp_decrypt (dp_decrypt),
      .dp_result  (dp_result),
`ifdef AES_SEQ_ABORT_EN
      .abort      (abort),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] b;
      b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
      logic [127:0] t;
      for (int i = 0; i < 16; i++)
         t[127-8*i -: 8] = inv ? isbox_t[s[127-8*i -: 8]] : sbox_t[s[127-8*i -: 8]];
      return t;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] t;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!inv) t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            else      t[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
         end
      end
      return t;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
      logic [127:0] t;
      logic [7:0]   m [4];
      logic [7:0]   acc;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-r+4)%4], s[127-8*(4*c+j) -: 8]);
            t[127-8*(4*c+r) -: 8] = acc;
         end
      end
      return t;
   endfunction

   function automatic logic [127:0] model_round(input logic [127:0] s, input logic [1:0] kind,
                                                input logic [3:0] rnd, input logic dec);
      logic [127:0] t;
      if (kind == 2'd0) return s ^ rk[rnd];
      if (!dec) begin
         t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
         if (kind == 2'd1) t = mix_cols(t, 1'b0);
         return t ^ rk[rnd];
      end
      t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[rnd];
      if (kind == 2'd1) t = mix_cols(t, 1'b1);
      return t;
   endfunction

   assign dp_result = model_round(dp_state, dp_kind, dp_round, dp_decrypt);

   task automatic expand_key(input logic [191:0] key);
      logic [31:0] w [52];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
      for (int i = 6; i < 52; i++) begin
         tmp = w[i-1];
         if (i % 6 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_t[tmp[31:24]] ^ rc, sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
            rc  = xt(rc);
         end
         w[i] = w[i-6] ^ tmp;
      end
      for (int r = 0; r < 13; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 13; r < 16; r++) rk[r] = '0;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},   bus.in_ready,  1);
      check({tag, "_out_valid"},  bus.out_valid, 0);
      check({tag, "_busy"},       busy,          0);
      check({tag, "_out_block"},  bus.out_block, 0);
      check({tag, "_dp_state"},   dp_state,      0);
      check({tag, "_dp_round"},   dp_round,      0);
      check({tag, "_dp_kind"},    dp_kind,       0);
      check({tag, "_dp_decrypt"}, dp_decrypt,    0);
   endtask

   // inputs are scrambled after acceptance; the sequencer must ignore them
   task automatic start_req(input logic dec, input logic [127:0] blk);
      check("idle_in_ready", bus.in_ready, 1);
      bus.in_valid   = 1'b1;
      bus.in_decrypt = dec;
      bus.in_block   = blk;
      tick();
      bus.in_valid   = 1'b0;
      bus.in_decrypt = ~dec;
      bus.in_block   = ~blk;
      check("run_in_ready", bus.in_ready, 0);
   endtask

   task automatic follow_run(input logic dec, input logic [127:0] exp, input string tag);
      for (int i = 0; i <= 12; i++) begin
         check({tag, "_dp_round"},  dp_round, dec ? (12 - i) : i);
         check({tag, "_dp_kind"},   dp_kind, (i == 0) ? 0 : ((i == 12) ? 2 : 1));
         check({tag, "_early_out_valid"}, bus.out_valid, 0);
         check({tag, "_busy"},      busy, 1);
         tick();
      end
      check({tag, "_out_valid"},  bus.out_valid, 1);
      check({tag, "_out_block"},  bus.out_block, exp);
      check({tag, "_dp_decrypt"}, dp_decrypt, dec);
      check({tag, "_done_in_ready"}, bus.in_ready, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   initial begin
      int           n_acc;
      int           n_res;
      int           acc_cyc [2];
      logic [127:0] res     [2];
      logic         seen_valid;

      for (int i = 0; i < 256; i++) begin
         sbox_t[i] = sbox_calc(8'(i));
         isbox_t[sbox_t[i]] = 8'(i);
      end
      expand_key(KEY);

      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_decrypt = 1'b0;
      bus.in_block   = '0;
      bus.out_ready  = 1'b0;
`ifdef AES_SEQ_ABORT_EN
      abort          = 1'b0;
`endif
      tick();
      tick();
      check_reset_values("reset");
      rst_n = 1'b1;
      tick();

      // encrypt, then immediate handshake
      start_req(1'b0, PT);
      follow_run(1'b0, CT, "enc");
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("enc_after_hs_out_valid", bus.out_valid, 0);
      check("enc_after_hs_in_ready", bus.in_ready, 1);

      // decrypt, then 20 cycles of backpressure with a pending request
      start_req(1'b1, CT);
      follow_run(1'b1, PT, "dec");
      bus.in_valid = 1'b1;
      bus.in_block = 128'hdeadbeef_00000000_cafef00d_12345678;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_out_block", bus.out_block, PT);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("bp_hs_out_valid", bus.out_valid, 0);
      check("bp_hs_in_ready", bus.in_ready, 1);
      check("bp_hs_busy", busy, 0);

      // asynchronous reset in RUN cycle 6
      start_req(1'b0, PT);
      for (int i = 0; i < 6; i++) tick();
      check("pre_reset_round", dp_round, 6);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_run_reset");
      tick();
      rst_n = 1'b1;
      tick();
      start_req(1'b0, PT);
      follow_run(1'b0, CT, "rerun");
      bus.out_ready = 1'b1;
      tick();
      check("rerun_hs_out_valid", bus.out_valid, 0);

      // back-to-back with in_valid and out_ready held high
      n_acc = 0;
      n_res = 0;
      acc_cyc[0] = -1; acc_cyc[1] = -1;
      res[0] = '0; res[1] = '0;
      bus.in_valid   = 1'b1;
      bus.in_decrypt = 1'b0;
      bus.in_block   = PT;
      for (int c = 0; c < 40; c++) begin
         if (bus.in_ready && bus.in_valid && n_acc < 2) begin
            acc_cyc[n_acc] = c;
            n_acc++;
         end
         if (bus.out_valid && bus.out_ready && n_res < 2) begin
            res[n_res] = bus.out_block;
            n_res++;
         end
         tick();
         if (n_acc == 1) begin
            bus.in_decrypt = 1'b1;
            bus.in_block   = CT;
         end
         if (n_acc == 2) bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b0;
      check("b2b_accepts", n_acc, 2);
      check("b2b_interval", acc_cyc[1] - acc_cyc[0], 15);
      check("b2b_results", n_res, 2);
      check("b2b_result0", res[0], CT);
      check("b2b_result1", res[1], PT);

`ifdef AES_SEQ_ABORT_EN
      // abort at RUN cycle 4, then abort held during an IDLE acceptance
      start_req(1'b0, PT);
      for (int i = 0; i < 4; i++) tick();
      check("pre_abort_round", dp_round, 4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_dp_state", dp_state, 0);
      check("abort_dp_round", dp_round, 0);
      seen_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         seen_valid = seen_valid | bus.out_valid;
         tick();
      end
      check("abort_no_out_valid", seen_valid, 0);
      abort = 1'b1;
      start_req(1'b0, PT);
      abort = 1'b0;
      follow_run(1'b0, CT, "post_abort");
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("post_abort_hs_out_valid", bus.out_valid, 0);
`else
      seen_valid = 1'b0;
      check("idle_out_valid", bus.out_valid | seen_valid, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
